window_reader: RTL and testbench
================================

WINDOW_READER -- requirements
Module: window_reader

Interface
REQ-001 Parameter BUS_WIDTH, default 32: width of one pixel word.
REQ-002 Parameter ROWS, default 3: number of buffered rows; also the window width in columns.
REQ-003 Parameter MAX_ROW_WIDTH, default 1024: largest supported row length.
REQ-004 Parameter ADDR_WIDTH, default $clog2(MAX_ROW_WIDTH): read-address width.
REQ-005 Parameter READ_LATENCY, default 2: cycles from r_en to rows_data valid.
REQ-006 Parameter FIFO_DEPTH, default 4: output window FIFO entries, power of two.
REQ-007 Ports clk (in, 1) and rst_n (in, 1): one clock; reset is asynchronous and active-low.
REQ-008 row_width  in  32  pixels per row, latched at row start.
REQ-009 buf_full  in  1  row buffer holds ROWS complete rows.
REQ-010 rows_data  in  ROWS*BUS_WIDTH  one column of ROWS vertical pixels; slice r is row r, row 0 the oldest.
REQ-011 r_en  out  1  read strobe to the row buffer.
REQ-012 r_add  out  ADDR_WIDTH  column read address.
REQ-013 win_data  out  ROWS*ROWS*BUS_WIDTH  window; slice (c*ROWS+r) is row r, column c, with column 0 the leftmost.
REQ-014 win_valid / win_ready  out / in  1 each  window handshake; transfer occurs when both are high.
REQ-015 win_last  out  1  marks the final window of a row.
REQ-016 row_done  out  1  one-cycle pulse when a row sweep has fully drained.
REQ-017 cfg_err  out  1  row_width is illegal; held while the block is IDLE with an illegal width.

Function
REQ-018 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-019 IDLE->READ SHALL occur when buf_full=1 and ROWS<=row_width<=MAX_ROW_WIDTH; row_width is latched as W on this transition.
REQ-020 In IDLE with an illegal row_width, the block SHALL assert cfg_err and issue no reads.
REQ-021 In READ, r_en SHALL be asserted only when fifo_count+inflight<FIFO_DEPTH; otherwise r_en=0 and r_add holds.
REQ-022 r_add SHALL start at 0 and increment by 1 per issued read, ending at W-1; reads are issued in consecutive cycles whenever credit allows.
REQ-023 After the read at W-1, the FSM SHALL enter DRAIN with r_en=0 and r_add=0.
REQ-024 The capture strobe SHALL be r_en delayed by READ_LATENCY cycles through an internal shift register; the rows_buffer valid output is not used.
REQ-025 On each capture, the column SHALL shift into a (ROWS-1)-column history.
REQ-026 For capture index k>=ROWS-1, a window SHALL be written to the FIFO in the capture cycle, made of the history plus the incoming column.
REQ-027 W-ROWS+1 windows SHALL be produced per row; win_last SHALL accompany the window written at capture index W-1.
REQ-028 FIFO read data SHALL be registered: a window written at the end of cycle N is visible at win_valid no earlier than cycle N+1.
REQ-029 win_data and win_last SHALL remain stable while win_valid=1 and win_ready=0.
REQ-030 DRAIN->IDLE SHALL occur when inflight=0 and all captures are complete; row_done pulses in that cycle and the column history clears.
REQ-031 FIFO windows not yet consumed SHALL persist across DRAIN->IDLE.
REQ-032 A following row SHALL be allowed to start while the FIFO is non-empty.
REQ-033 A buf_full drop during READ SHALL be ignored; the buffer clears full on the final address.
REQ-034 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-035 The FIFO SHALL never overflow.

Reset
REQ-036 While rst_n=0: FSM=IDLE; r_en=0, r_add=0, win_valid=0, win_last=0, row_done=0, cfg_err=0; FIFO empty, inflight=0, latency pipe cleared.
REQ-037 Assertion of rst_n mid-row SHALL discard in-flight data; no window from that row appears after reset.

Structure
REQ-038 The default parameters and FSM state encodings SHALL live in a shared package, conv_pkg.
REQ-039 The output FIFO SHALL be the sub-module window_fifo (parameterised width and depth, count output).

Verification
REQ-040 W=5, buf_full=1, win_ready=1: first r_en at cycle T with r_add 0..4 over T..T+4 → 3 windows, first win_valid at T+5, win_last on the 3rd, row_done once.
REQ-041 W=8, win_ready=0 → exactly 4 windows buffered, r_en stalls with r_add held; releasing win_ready → remaining 2 windows, none lost or duplicated.
REQ-042 row_width=2 or 2000 with buf_full=1 → cfg_err=1, r_en never asserted.
REQ-043 Reset pulse at r_add=3 of W=6 → all outputs at reset values; the next row sweep starts at r_add=0 with clean windows.
REQ-044 buf_full=0 → no reads; two back-to-back rows with W=4 → 2+2 windows in order, win_last on the 2nd and 4th.
REQ-045 Random win_ready toggling over 10 rows → window contents match a reference model; the FIFO never overflows.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults and state encoding for the window reader.
//   BUS_WIDTH_DEF      pixel word width
//   ROWS_DEF           buffered rows, also the window width in columns
//   MAX_ROW_WIDTH_DEF  largest legal row length
//   READ_LATENCY_DEF   row-buffer read latency in cycles
//   FIFO_DEPTH_DEF     output window FIFO entries (power of two)
package conv_pkg;

  localparam int BUS_WIDTH_DEF     = 32;
  localparam int ROWS_DEF          = 3;
  localparam int MAX_ROW_WIDTH_DEF = 1024;
  localparam int READ_LATENCY_DEF  = 2;
  localparam int FIFO_DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/window_fifo.sv
// Small synchronous FIFO holding finished windows.
// Storage is flops, so an entry written at the end of cycle N is first
// visible on rd_data in cycle N+1; rd_data is stable until popped.
// Ports:
//   clk, rst_n   clock, async active-low reset (FIFO empties)
//   push/wr_data write one entry (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   rd_data      head entry
//   count        number of stored entries
module window_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CNT_FULL);
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/window_reader.sv
// Sweeps one row of a ROWS-deep row buffer column by column and emits
// ROWS x ROWS pixel windows through a small output FIFO.
//
// state | meaning
// IDLE  | waiting for a full buffer and a legal row_width
// READ  | issuing column reads, throttled by FIFO credit
// DRAIN | all reads issued, waiting for in-flight columns to land
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   row_width          pixels per row, latched when a sweep starts
//   buf_full           row buffer holds ROWS complete rows
//   rows_data          one column, slice r = row r (row 0 oldest)
//   r_en, r_add        read strobe and column address to the row buffer
//   win_data           window, slice (c*ROWS+r) = row r, column c
//   win_valid/ready    window handshake
//   win_last           final window of a row
//   row_done           one-cycle pulse when a sweep has drained
//   cfg_err            row_width illegal while idle
module window_reader
  import conv_pkg::*;
#(
  parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
  parameter int ROWS          = ROWS_DEF,
  parameter int MAX_ROW_WIDTH = MAX_ROW_WIDTH_DEF,
  parameter int ADDR_WIDTH    = $clog2(MAX_ROW_WIDTH),
  parameter int READ_LATENCY  = READ_LATENCY_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   row_width,
  input  logic                          buf_full,
  input  logic [ROWS*BUS_WIDTH-1:0]     rows_data,
  output logic                          r_en,
  output logic [ADDR_WIDTH-1:0]         r_add,
  output logic [ROWS*ROWS*BUS_WIDTH-1:0] win_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic                          win_last,
  output logic                          row_done,
  output logic                          cfg_err
);

  localparam int COL_W  = ROWS * BUS_WIDTH;
  localparam int WIN_W  = ROWS * COL_W;
  localparam int HIST_W = (ROWS - 1) * COL_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W  = $clog2(READ_LATENCY + 1) + 1;

  localparam logic [ADDR_WIDTH:0]   ONE_W = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [INF_W-1:0]      ONE_I = 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     width_q, width_d;
  logic [ADDR_WIDTH-1:0]   r_add_q, r_add_d;
  logic [READ_LATENCY-1:0] lat_q, lat_d;
  logic [INF_W-1:0]        inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]   cap_idx_q, cap_idx_d;
  logic [HIST_W-1:0]       hist_q, hist_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    width_ok, credit, cap, push, pop;
  logic [ADDR_WIDTH-1:0]   last_idx;
  logic [WIN_W-1:0]        col_cat;
  logic [WIN_W:0]          fifo_rd;
  logic [CNT_W-1:0]        fifo_count;

  assign width_ok = (row_width >= 32'(ROWS)) && (row_width <= 32'(MAX_ROW_WIDTH));
  assign last_idx = ADDR_WIDTH'(width_q - ONE_W);
  // Credit counts every outstanding read, including the first ROWS-1
  // columns that never become windows; this keeps the FIFO from overflowing.
  assign credit   = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    r_add_d  = r_add_q;
    r_en     = 1'b0;
    row_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_full && width_ok) begin
          state_d = READ;
          width_d = row_width[ADDR_WIDTH:0];
          r_add_d = '0;
        end
      end
      READ: begin
        if (credit) begin
          r_en = 1'b1;
          if (r_add_q == last_idx) begin
            state_d = DRAIN;
            r_add_d = '0;
          end else begin
            r_add_d = r_add_q + ONE_A;
          end
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d  = IDLE;
          row_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap      = lat_q[READ_LATENCY-1];
    lat_d    = lat_q << 1;
    lat_d[0] = r_en;
    // Incoming column sits in the rightmost window column.
    col_cat  = {rows_data, hist_q};

    inflight_d = inflight_q;
    if (r_en && !cap) begin
      inflight_d = inflight_q + ONE_I;
    end else if (!r_en && cap) begin
      inflight_d = inflight_q - ONE_I;
    end

    cap_idx_d = cap_idx_q;
    hist_d    = hist_q;
    if (row_done) begin
      cap_idx_d = '0;
      hist_d    = '0;
    end else if (cap) begin
      cap_idx_d = cap_idx_q + ONE_A;
      hist_d    = col_cat[WIN_W-1 -: HIST_W];
    end

    push      = cap && (cap_idx_q >= ADDR_WIDTH'(ROWS - 1));
    cfg_err_d = (state_q == IDLE) && !width_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      width_q    <= '0;
      r_add_q    <= '0;
      lat_q      <= '0;
      inflight_q <= '0;
      cap_idx_q  <= '0;
      hist_q     <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      r_add_q    <= r_add_d;
      lat_q      <= lat_d;
      inflight_q <= inflight_d;
      cap_idx_q  <= cap_idx_d;
      hist_q     <= hist_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  window_fifo #(
    .WIDTH(WIN_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_data({cap_idx_q == last_idx, col_cat}),
    .pop    (pop),
    .rd_data(fifo_rd),
    .count  (fifo_count)
  );

  assign win_valid = (fifo_count != '0);
  assign pop       = win_valid && win_ready;
  assign win_data  = fifo_rd[WIN_W-1:0];
  assign win_last  = win_valid && fifo_rd[WIN_W];
  assign r_add     = r_add_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_window_reader.sv
module tb_window_reader;

  localparam int BW   = 32;
  localparam int R    = 3;
  localparam int WINW = R * R * BW;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        row_width;
  logic               buf_full;
  logic [R*BW-1:0]    rows_data;
  logic               r_en;
  logic [9:0]         r_add;
  logic [WINW-1:0]    win_data;
  logic               win_valid;
  logic               win_ready;
  logic               win_last;
  logic               row_done;
  logic               cfg_err;

  window_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_width(row_width),
    .buf_full (buf_full),
    .rows_data(rows_data),
    .r_en     (r_en),
    .r_add    (r_add),
    .win_data (win_data),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_last (win_last),
    .row_done (row_done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Row-buffer model: a read issued in cycle T returns its column in T+2.
  int m_seq = 0, m_a1 = 0, m_a2 = 0, m_s1 = 0, m_s2 = 0;

  function automatic logic [31:0] pix(input int s, input int r, input int a);
    logic [31:0] v;
    v = {s[7:0], r[7:0], a[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin
    if (r_en && r_add == 10'd0) m_seq <= m_seq + 1;
    m_s1 <= (r_en && r_add == 10'd0) ? m_seq + 1 : m_seq;
    m_a1 <= int'(r_add);
    m_s2 <= m_s1;
    m_a2 <= m_a1;
  end

  always_comb begin
    rows_data = '0;
    for (int r = 0; r < R; r++) rows_data[r*BW +: BW] = pix(m_s2, r, m_a2);
  end

  // Observation state
  int              cyc = 0, ren_cnt, done_cnt, first_ren, first_valid;
  int              rows_left = 0, rdy_mode = 0, exp_seq = 0;
  int              add_log[$];
  logic [WINW:0]   got_q[$];
  logic [WINW:0]   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [WINW:0] obs, input logic [WINW:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ren_cnt = 0; done_cnt = 0; first_ren = -1; first_valid = -1;
    add_log.delete();
  endtask

  task automatic add_exp(input int seq, input int w);
    logic [WINW:0] e;
    for (int j = 0; j <= w - R; j++) begin
      e = '0;
      for (int c = 0; c < R; c++)
        for (int r = 0; r < R; r++) e[(c*R+r)*BW +: BW] = pix(seq, r, j + c);
      e[WINW] = (j == w - R);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (r_en) begin
      ren_cnt++;
      add_log.push_back(int'(r_add));
      if (first_ren < 0) first_ren = cyc;
      if (int'(r_add) == int'(row_width) - 1) begin
        rows_left--;
        if (rows_left <= 0) buf_full = 1'b0;
      end
    end
    if (row_done) done_cnt++;
    if (rdy_mode == 2) win_ready = 1'($urandom_range(0, 1));
    else win_ready = (rdy_mode == 0);
    if (win_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (win_ready) got_q.push_back({win_last, win_data});
    end
  endtask

  task automatic wait_rows(input int n, input int max, input string tag);
    int i;
    i = 0;
    while (i < max && !(done_cnt >= n && got_q.size() >= exp_q.size())) begin
      step();
      i++;
    end
    chk({"timeout_", tag}, 64'(i < max), 64'd1);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk_win($sformatf("%s_win%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_r_en"},      64'(r_en),      64'd0);
    chk({tag, "_r_add"},     64'(r_add),     64'd0);
    chk({tag, "_win_valid"}, 64'(win_valid), 64'd0);
    chk({tag, "_win_last"},  64'(win_last),  64'd0);
    chk({tag, "_row_done"},  64'(row_done),  64'd0);
    chk({tag, "_cfg_err"},   64'(cfg_err),   64'd0);
  endtask

  initial begin
    rst_n = 1'b0; buf_full = 1'b0; row_width = 32'd5; win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // No reads without a full buffer
    clr();
    repeat (6) step();
    chk("idle_no_read", 64'(ren_cnt), 64'd0);
    chk("idle_cfg_err", 64'(cfg_err), 64'd0);

    // W=5, always ready: addresses 0..4, 3 windows, first valid 5 cycles after first read
    clr();
    row_width = 32'd5; rows_left = 1; rdy_mode = 0;
    exp_seq++; add_exp(exp_seq, 5);
    buf_full = 1'b1;
    wait_rows(1, 60, "w5");
    chk("w5_reads", 64'(ren_cnt), 64'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("w5_addr%0d", i), 64'(add_log[i]), 64'(i));
    chk("w5_latency", 64'(first_valid - first_ren), 64'd5);
    chk("w5_row_done", 64'(done_cnt), 64'd1);
    compare("w5");

    // W=8, consumer stalled: 4 windows fill the FIFO, reads stop at address 6
    clr();
    row_width = 32'd8; rows_left = 1; rdy_mode = 1;
    exp_seq++; add_exp(exp_seq, 8);
    buf_full = 1'b1;
    repeat (30) step();
    chk("w8_stall_reads", 64'(ren_cnt), 64'd6);
    chk("w8_stall_r_en", 64'(r_en), 64'd0);
    chk("w8_stall_r_add", 64'(r_add), 64'd6);
    chk("w8_stall_valid", 64'(win_valid), 64'd1);
    chk("w8_stall_none_taken", 64'(got_q.size()), 64'd0);
    rdy_mode = 0;
    wait_rows(1, 80, "w8");
    chk("w8_reads", 64'(ren_cnt), 64'd8);
    compare("w8");

    // Illegal widths
    clr();
    row_width = 32'd2; buf_full = 1'b1;
    repeat (8) step();
    chk("w2_no_read", 64'(ren_cnt), 64'd0);
    chk("w2_cfg_err", 64'(cfg_err), 64'd1);
    row_width = 32'd2000;
    repeat (8) step();
    chk("w2000_no_read", 64'(ren_cnt), 64'd0);
    chk("w2000_cfg_err", 64'(cfg_err), 64'd1);
    buf_full = 1'b0; row_width = 32'd4;
    repeat (2) step();
    chk("legal_cfg_err_clear", 64'(cfg_err), 64'd0);

    // Two back-to-back rows of W=4
    clr();
    row_width = 32'd4; rows_left = 2;
    exp_seq++; add_exp(exp_seq, 4);
    exp_seq++; add_exp(exp_seq, 4);
    buf_full = 1'b1;
    wait_rows(2, 100, "b2b");
    chk("b2b_reads", 64'(ren_cnt), 64'd8);
    chk("b2b_row_done", 64'(done_cnt), 64'd2);
    compare("b2b");

    // Reset in the middle of a W=6 sweep
    clr();
    row_width = 32'd6; rows_left = 1; buf_full = 1'b1;
    exp_seq++;
    for (int i = 0; i < 30; i++) begin
      step();
      if (r_en && r_add == 10'd3) break;
    end
    chk("mid_rst_at_addr3", 64'(r_add), 64'd3);
    rst_n = 1'b0; buf_full = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_q.delete();
    clr();
    repeat (10) step();
    chk("post_rst_no_read", 64'(ren_cnt), 64'd0);
    chk("post_rst_no_window", 64'(got_q.size()), 64'd0);
    rows_left = 1;
    exp_seq++; add_exp(exp_seq, 6);
    buf_full = 1'b1;
    wait_rows(1, 80, "w6");
    chk("w6_first_addr", 64'(add_log[0]), 64'd0);
    chk("w6_reads", 64'(ren_cnt), 64'd6);
    compare("w6");

    // Ten rows with a randomly stalling consumer
    clr();
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) begin
      int w, k;
      w = 3 + (i * 3) % 7;
      row_width = 32'(w); rows_left = 1;
      exp_seq++; add_exp(exp_seq, w);
      buf_full = 1'b1;
      k = 0;
      while (k < 300 && done_cnt < i + 1) begin
        step();
        k++;
      end
      chk($sformatf("rnd_row%0d_timeout", i), 64'(k < 300), 64'd1);
    end
    rdy_mode = 0;
    wait_rows(10, 100, "rnd_drain");
    chk("rnd_row_done", 64'(done_cnt), 64'd10);
    compare("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
